smem_result_collector: RTL
==========================

Name: smem_result_collector

Overview:
- Consumer end of the SMEM result output interface: grants permission to the result RAM and accepts its 512-bit beat stream (group header followed by mem-entry payload beats).
- Checks the group framing and buffers beats in an internal FIFO.
- Drains the FIFO to the host write channel with valid/ready and a linearly incrementing write address.
- Throttles the producer through a registered stall output.

Parameters:
FIFO_DEPTH, 16, beat FIFO entries (power of 2, >= 4)
ADDR_W, 32, host byte-address width
BEAT_BYTES, 64, address increment per beat

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; captures batch_size and base_addr, starts a batch
batch_size  in  9  number of reads (groups) expected
base_addr  in  ADDR_W  host address of first beat
up_request  in  1  producer has results ready
up_permit  out  1  grant to producer
up_data  in  512  producer beat
up_valid  in  1  up_data valid this cycle
up_finish  in  1  producer has sent all groups
up_stall  out  1  backpressure into producer pipeline stall
out_valid  out  1  host beat valid
out_ready  in  1  host accepts beat
out_data  out  512  host beat
out_addr  out  ADDR_W  host byte address of out_data
out_hdr  out  1  out_data is a group header
busy  out  1  batch in progress
done  out  1  batch complete, held until next start
err_seq  out  1  sticky framing error
err_ovf  out  1  sticky FIFO overflow
beat_count  out  16  beats delivered to host this batch

Behaviour:
- Reset: all outputs 0, FSM = IDLE, FIFO empty, all counters 0.
- Beat format:
  - Header: [9:0] read number, [70:64] mem_size, [159:128] ret.
  - Payload: entry k in [255:0], entry k+1 in [511:256]; if mem_size is odd, the last beat carries only the low half (upper half 0).
  - Producer inserts idle (up_valid = 0) cycles between groups.
- FSM:
  - IDLE: start -> WAIT; latch batch_size and base_addr; clear counters, err_seq, err_ovf and done; busy = 1.
  - WAIT: up_request = 1 -> RUN; up_permit = 1 from the next cycle.
  - RUN: up_permit stays 1. up_finish = 1 -> DRAIN; up_permit drops the next cycle.
  - DRAIN: FIFO empty and no host beat pending -> IDLE; done = 1, busy = 0.
  - start outside IDLE is ignored.
- Framing check (RUN only, on up_valid):
  - When expecting a header: capture mem_size; payload_left = ceil(mem_size / 2), 7-bit arithmetic.
  - If read number != expected_read (starts at 0, increments per header): set err_seq.
  - mem_size = 0: no payload expected; next valid beat must be a header.
  - Each payload beat decrements payload_left; at 0, expect a header.
  - A header-looking beat counts as payload while payload_left > 0 (no content sniffing).
  - At up_finish: if expected_read != batch_size or payload_left != 0, set err_seq.
  - err_seq never blocks data flow.
- FIFO:
  - Entry = {hdr flag, 512-bit data}.
  - Push on up_valid in RUN; pop on out_valid && out_ready. Simultaneous push and pop allowed, including when full.
  - Push when full and no pop: beat dropped, err_ovf set.
- up_stall:
  - Registered. Next value = 1 when post-update occupancy >= FIFO_DEPTH - 3.
  - The 3-entry margin covers the stall register plus the producer's registered output beat.
  - Forced 0 outside RUN.
- Host side:
  - out_valid = FIFO non-empty. out_data and out_hdr come from the FIFO head.
  - out_data, out_hdr and out_addr hold stable while out_valid && !out_ready.
  - out_addr = base_addr + beat_count * BEAT_BYTES (ADDR_W wrap).
  - beat_count increments on each accepted beat and saturates at 0xFFFF.
- reset_n low mid-batch: everything returns to reset values on that edge, FIFO contents discarded; producer must also be reset.

Test Plan:
- Basic batch: batch_size = 2, groups {read 0, mem_size 3, ret 5} and {read 1, mem_size 2, ret 7}, out_ready = 1. Expect 5 beats at base 0x1000 with addresses 0x1000, 0x1040, 0x1080, 0x10C0, 0x1100; out_hdr = 1 on beats 0 and 3; done = 1; beat_count = 5; no errors.
- Empty group: batch_size = 1, mem_size = 0. Expect exactly 1 header beat, then done; err_seq = 0.
- Backpressure: FIFO_DEPTH = 16, out_ready = 0 while sending 40 beats. up_stall rises by occupancy 13; no beat is lost; err_ovf = 0. Then out_ready = 1: all 40 beats delivered in order, addresses contiguous.
- Host stall stability: toggle out_ready every cycle. out_data and out_addr are unchanged during every not-ready cycle.
- Framing errors:
  - Header read number 1 where 0 is expected -> err_seq = 1.
  - Separately, up_finish with batch_size = 3 after 2 groups -> err_seq = 1; data is still drained and done = 1.
- Overflow and reset: ignore up_stall in the bench, hold out_ready = 0, push 20 beats -> err_ovf = 1, FIFO holds 16. Assert reset_n low mid-drain -> all outputs 0 next cycle; a new start works normally.

Source files
------------

// File: rtl/smem_result_collector.sv
// SMEM result collector: accepts the result RAM beat stream, checks group
// framing, buffers beats in a FIFO and drains them to the host write channel.
module smem_result_collector #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [8:0]        batch_size,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              up_request,
    output logic              up_permit,
    input  logic [511:0]      up_data,
    input  logic              up_valid,
    input  logic              up_finish,
    output logic              up_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [511:0]      out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_hdr,
    output logic              busy,
    output logic              done,
    output logic              err_seq,
    output logic              err_ovf,
    output logic [15:0]       beat_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [8:0]        batch_q;
    logic [ADDR_W-1:0] base_q;
    logic [9:0]        exp_read;
    logic [9:0]        exp_read_nx;
    logic [6:0]        payload_left;
    logic [6:0]        payload_nx;
    logic [6:0]        size_p1;
    logic [6:0]        hdr_left;
    logic              seq_hit;
    logic              err_seq_q;
    logic              err_ovf_q;
    logic              done_q;
    logic              busy_q;
    logic              stall_q;
    logic [15:0]       beat_cnt_q;

    logic [512:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nx;
    logic [512:0]      head;

    logic run;
    logic is_hdr;
    logic push;
    logic pop;
    logic full;
    logic push_ok;
    logic ovf;
    logic start_ok;
    logic finish_ok;
    logic drain_done;

    assign run        = (state == S_RUN);
    assign is_hdr     = (payload_left == 7'd0);
    assign push       = run && up_valid;
    assign full       = (count == FULL_LVL);
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign push_ok    = push && (!full || pop);
    assign ovf        = push && full && !pop;
    assign start_ok   = (state == S_IDLE) && start;
    assign finish_ok  = run && up_finish;
    assign drain_done = (state == S_DRAIN) && (count == '0);

    assign head       = mem[rd_ptr];
    assign out_data   = out_valid ? head[511:0] : '0;
    assign out_hdr    = out_valid && head[512];
    assign out_addr   = base_q + ADDR_W'(beat_cnt_q) * ADDR_W'(BEAT_BYTES);

    assign up_permit  = run;
    assign up_stall   = stall_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_seq    = err_seq_q;
    assign err_ovf    = err_ovf_q;
    assign beat_count = beat_cnt_q;

    // Batch sequencing: idle, wait for producer, stream, drain FIFO
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_WAIT;
            S_WAIT:  if (up_request) state_nx = S_RUN;
            S_RUN:   if (up_finish) state_nx = S_DRAIN;
            S_DRAIN: if (count == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Group framing: header sets payload length, payload beats count down
    always_comb begin
        size_p1     = up_data[70:64] + 7'd1;
        hdr_left    = size_p1 >> 1;
        payload_nx  = payload_left;
        exp_read_nx = exp_read;
        seq_hit     = 1'b0;
        if (push) begin
            if (is_hdr) begin
                payload_nx  = hdr_left;
                exp_read_nx = exp_read + 10'd1;
                if (up_data[9:0] != exp_read) seq_hit = 1'b1;
            end else begin
                payload_nx = payload_left - 7'd1;
            end
        end
        if (finish_ok) begin
            if (exp_read != {1'b0, batch_q}) seq_hit = 1'b1;
            if (payload_left != 7'd0) seq_hit = 1'b1;
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nx = count;
        if (push_ok && !pop) count_nx = count + CNT_W'(1);
        else if (!push_ok && pop) count_nx = count - CNT_W'(1);
    end

    // FSM state, batch control and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            batch_q      <= '0;
            base_q       <= '0;
            exp_read     <= '0;
            payload_left <= '0;
            err_seq_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            stall_q      <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            stall_q <= (state_nx == S_RUN) && (count_nx >= STALL_LVL);
            if (start_ok) begin
                batch_q      <= batch_size;
                base_q       <= base_addr;
                exp_read     <= '0;
                payload_left <= '0;
                err_seq_q    <= 1'b0;
                err_ovf_q    <= 1'b0;
                done_q       <= 1'b0;
                busy_q       <= 1'b1;
                beat_cnt_q   <= '0;
            end else begin
                exp_read     <= exp_read_nx;
                payload_left <= payload_nx;
                if (seq_hit) err_seq_q <= 1'b1;
                if (ovf) err_ovf_q <= 1'b1;
                if (drain_done) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                if (pop && beat_cnt_q != 16'hFFFF)
                    beat_cnt_q <= beat_cnt_q + 16'd1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nx;
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {is_hdr, up_data};
    end

endmodule
